// File: rtl/skew_feeder_if.sv
// skew_feeder_if
//   Bundles the tile-pass control, the north FIFO read side and the skewed
//   operand bus that the feeder presents to the MAC array top row.
//
//   start/len   : request a pass of len rows per column
//   fifo_data   : flattened FIFO outputs, column i at [i*DATA_SIZE +: DATA_SIZE]
//   fifo_empty  : per-column FIFO empty flags
//   fifo_rd_en  : per-column FIFO read enables
//   mac_data    : skewed operands, same packing as fifo_data
//   mac_valid   : per-column operand valid
//   busy/done/stall : pass status
//
//   master : the side that issues passes and owns the FIFOs
//   slave  : the feeder itself
interface skew_feeder_if #(
   parameter int MAC_WIDTH = 256,
   parameter int DATA_SIZE = 8
);
   logic                           start;
   logic [7:0]                     len;
   logic [MAC_WIDTH*DATA_SIZE-1:0] fifo_data;
   logic [MAC_WIDTH-1:0]           fifo_empty;
   logic [MAC_WIDTH-1:0]           fifo_rd_en;
   logic [MAC_WIDTH*DATA_SIZE-1:0] mac_data;
   logic [MAC_WIDTH-1:0]           mac_valid;
   logic                           busy;
   logic                           done;
   logic                           stall;

   modport master (
      output start, len, fifo_data, fifo_empty,
      input  fifo_rd_en, mac_data, mac_valid, busy, done, stall
   );

   modport slave (
      input  start, len, fifo_data, fifo_empty,
      output fifo_rd_en, mac_data, mac_valid, busy, done, stall
   );
endinterface

// File: rtl/skew_feeder.sv
// skew_feeder
//   Reads MAC_WIDTH north FIFOs in a staircase pattern (column i starts i
//   cycles after column 0) and registers the FIFO outputs onto the MAC top
//   row. A pass reads exactly K = len entries from every column. If any
//   column that is due to be read is empty, the whole array stalls so the
//   skew between columns is preserved.
//
//   clk   : clock, rising edge
//   reset : asynchronous, active-low
//   bus   : skew_feeder_if.slave (control, FIFO read side, MAC operand side)
module skew_feeder #(
   parameter int MAC_WIDTH = 256,
   parameter int DATA_SIZE = 8
) (
   input  logic          clk,
   input  logic          reset,
   skew_feeder_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } state_t;

   state_t                         state_q, state_d;
   logic [8:0]                     cnt_q, cnt_d;
   logic [7:0]                     k_q, k_d;
   logic                           flush_q, flush_d;
   logic                           done_q, done_d;
   logic [MAC_WIDTH-1:0]           rd_q, rd_d;
   logic [MAC_WIDTH-1:0]           valid_q, valid_d;
   logic [MAC_WIDTH*DATA_SIZE-1:0] data_q, data_d;

   logic [MAC_WIDTH-1:0]           active;
   logic [MAC_WIDTH-1:0]           rd_en;
   logic                           stall;
   logic                           last_cnt;

   // Column i is in its read window when i <= cnt <= i+K-1. The compare is
   // done one bit wider than cnt so i+K never wraps.
   always_comb begin
      active = '0;
      for (int i = 0; i < MAC_WIDTH; i++) begin
         active[i] = ({1'b0, cnt_q} >= 10'(i)) &&
                     ({1'b0, cnt_q} < (10'(i) + {2'b0, k_q}));
      end
   end

   // A single empty active column freezes every column, keeping the skew.
   always_comb begin
      stall    = (state_q == RUN) && (|(active & bus.fifo_empty));
      rd_en    = ((state_q == RUN) && !stall) ? active : '0;
      last_cnt = ({1'b0, cnt_q} == ({2'b0, k_q} + 10'(MAC_WIDTH) - 10'd2));
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      k_d     = k_q;
      flush_d = flush_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               if (bus.len != 8'd0) begin
                  state_d = RUN;
                  cnt_d   = 9'd0;
                  k_d     = bus.len;
               end else begin
                  // Empty pass: nothing to read, just acknowledge.
                  done_d = 1'b1;
               end
            end
         end
         RUN: begin
            if (!stall) begin
               if (last_cnt) begin
                  state_d = FLUSH;
                  flush_d = 1'b0;
               end else begin
                  cnt_d = cnt_q + 9'd1;
               end
            end
         end
         FLUSH: begin
            // Two cycles let the last read travel through the FIFO output
            // and our register; done lands the cycle after the last valid.
            if (flush_q) begin
               state_d = IDLE;
               flush_d = 1'b0;
               done_d  = 1'b1;
            end else begin
               flush_d = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // rd_q marks which FIFO outputs become valid this cycle; those are
   // captured, everything else is forced to zero on the MAC bus.
   always_comb begin
      rd_d    = rd_en;
      valid_d = rd_q;
      data_d  = '0;
      for (int i = 0; i < MAC_WIDTH; i++) begin
         if (rd_q[i]) begin
            data_d[i*DATA_SIZE +: DATA_SIZE] = bus.fifo_data[i*DATA_SIZE +: DATA_SIZE];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         k_q     <= '0;
         flush_q <= 1'b0;
         done_q  <= 1'b0;
         rd_q    <= '0;
         valid_q <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         k_q     <= k_d;
         flush_q <= flush_d;
         done_q  <= done_d;
         rd_q    <= rd_d;
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign bus.fifo_rd_en = rd_en;
   assign bus.mac_data   = data_q;
   assign bus.mac_valid  = valid_q;
   assign bus.busy       = (state_q != IDLE);
   assign bus.done       = done_q;
   assign bus.stall      = stall;

endmodule

// File: doc/skew_feeder.md
SKEW_FEEDER -- requirements
Module: skew_feeder

Interface
REQ-001 Parameter MAC_WIDTH, default 256, number of columns (north FIFOs) fed into the MAC array.
REQ-002 Parameter DATA_SIZE, default 8, data width per column in bits.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low; low clears all state immediately.
REQ-005 start  input  1  one-cycle request to begin a tile pass; sampled only in IDLE.
REQ-006 len  input  8  rows per column for the pass, K; sampled with start.
REQ-007 fifo_data  input  MAC_WIDTH*DATA_SIZE  flattened north FIFO data_out; column i at bits [i*DATA_SIZE +: DATA_SIZE].
REQ-008 fifo_empty  input  MAC_WIDTH  per-column FIFO empty flag.
REQ-009 fifo_rd_en  output  MAC_WIDTH  per-column FIFO read enable.
REQ-010 mac_data  output  MAC_WIDTH*DATA_SIZE  skewed operands to the MAC top row, same packing as fifo_data.
REQ-011 mac_valid  output  MAC_WIDTH  per-column operand valid.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 done  output  1  one-cycle pulse at end of pass.
REQ-014 stall  output  1  high in a RUN cycle that reads nothing because an active column is empty.

Function
REQ-015 States: IDLE, RUN, FLUSH. The FSM is one-hot or binary; only these three states are reachable.
REQ-016 IDLE: start=1 with len>=1 -> RUN; cnt<=0; K<=len.
REQ-016a IDLE: start=1 with len=0 -> no transition, no reads; done pulses on the next cycle.
REQ-017 Pass counter cnt is 9 bits wide. Column i is active when i <= cnt <= i+K-1, with the comparison done at 9-bit-plus-carry width and no wrap.
REQ-018 RUN, no stall: fifo_rd_en[i] = active(i) and cnt increments. The staircase skew is column i reading i cycles after column 0.
REQ-019 stall = RUN and (any active column has fifo_empty=1). On stall, all fifo_rd_en are 0 and cnt holds, so the skew is kept globally.
REQ-020 RUN ends after the non-stalled cycle where cnt = K+MAC_WIDTH-2. The next state is FLUSH.
REQ-021 FIFO data is valid the cycle after rd_en. The block registers it, so mac_data[i] and mac_valid[i] update 2 cycles after the fifo_rd_en[i] cycle.
REQ-022 When mac_valid[i]=0, mac_data[i] is 0.
REQ-023 FLUSH lasts 2 cycles to drain the pipeline. On its last cycle done=1, then the FSM returns to IDLE.
REQ-024 done goes high exactly one cycle after the final mac_valid pulse of column MAC_WIDTH-1.
REQ-025 start is ignored while busy; K does not change mid-pass.
REQ-026 Each column reads exactly K entries per pass, and each column produces exactly K mac_valid pulses.
REQ-027 fifo_rd_en is never asserted to a column whose fifo_empty=1.

Reset
REQ-028 While reset=0: state=IDLE, cnt=0, K=0, and all fifo_rd_en, mac_data, mac_valid, busy, done and stall are 0.
REQ-029 Reset mid-pass abandons the pass with no done pulse. The block does not modify FIFO contents; FIFO reset is separate.
REQ-030 On reset release, the first start is accepted on the first rising edge with reset=1.

Verification (MAC_WIDTH=4, DATA_SIZE=8)
REQ-031 Covers a basic pass:
- Stimulus: all FIFOs non-empty; start with len=3.
- rd_en pattern per cycle: 0001, 0011, 0111, 1110, 1100, 1000.
- mac_valid: the same pattern, 2 cycles later.
- done: pulses 1 cycle after the last mac_valid.
REQ-032 Covers an empty-FIFO stall:
- Stimulus: column 2 empty at cnt=2 for 3 cycles.
- Response: stall=1 for 3 cycles, rd_en=0000 during those cycles, cnt held.
- Check: the total pass is 3 cycles longer and the skew pattern is unchanged afterwards.
REQ-033 Covers len=0: start -> no rd_en, and done pulses on the next cycle.
REQ-034 Covers start while busy:
- Stimulus: a second start with len=5 issued mid-pass of len=2.
- Response: it is ignored; each column reads exactly 2 entries.
REQ-035 Covers reset mid-pass:
- Stimulus: reset=0 asserted at cnt=3.
- Response: all outputs are 0 immediately and no done pulse occurs.
- Check: a subsequent start with len=1 completes a normal pass.
REQ-036 Covers data integrity:
- Stimulus: column i FIFO holds values 8'h10*i+j for j=0..K-1.
- Response: mac_data column i presents the values in FIFO order; the bus is 0 when not valid.
